atm_keypad_entry: RTL
=====================

ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, idle cycles allowed between keys during entry before the partial entry is discarded.
REQ-002 Parameter MAX_TRIES, default 3, consecutive PIN rejections before lockout.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 key_valid  input  1  one-cycle key strobe.
REQ-007 key_code  input  4  key: 0x0-0x9 digit, 0xA CLEAR, 0xB BACKSPACE, 0xC ENTER, 0xD-0xF invalid.
REQ-008 field_sel  input  2  target field: 0 account, 1 PIN, 2 amount, 3 reserved.
REQ-009 pin_fail  input  1  one-cycle strobe from the ATM controller: submitted PIN rejected.
REQ-010 pin_ok  input  1  one-cycle strobe: submitted PIN accepted.
REQ-011 card_out  input  1  one-cycle strobe: session ended / card removed.
REQ-012 value  output  12  submitted entry, three BCD digits, first digit in [11:8].
REQ-013 value_field  output  2  field_sel captured with the submitted value.
REQ-014 value_valid  output  1  one-cycle submit pulse.
REQ-015 digit_count  output  2  digits currently held (0-3).
REQ-016 key_err  output  1  one-cycle pulse on a rejected key.
REQ-017 timeout  output  1  one-cycle pulse when an entry is discarded for inactivity.
REQ-018 locked  output  1  high while in LOCKED.

Function
REQ-019 FSM states IDLE, COLLECT, LOCKED; all outputs and state registered.
REQ-020 IDLE: digit key -> shift register loads the digit, digit_count=1, go COLLECT; CLEAR/BACKSPACE/ENTER/invalid -> key_err, stay IDLE.
REQ-021 COLLECT: digit with count<3 -> shift left 4 bits, insert the digit at [3:0], count+1.
REQ-022 COLLECT: digit with count=3 -> key_err, buffer unchanged.
REQ-023 BACKSPACE -> shift right 4 bits, count-1; if the count reaches 0, go IDLE.
REQ-024 CLEAR -> buffer=0, count=0, go IDLE, no key_err.
REQ-025 ENTER with count=3 -> the cycle after the key: value=buffer, value_field=field_sel at key time, value_valid=1 for one cycle; buffer and count clear; go IDLE.
REQ-026 ENTER with count<3 -> key_err, buffer kept.
REQ-027 Invalid codes (0xD-0xF) and field_sel=3 with any key -> key_err, no state change.
REQ-028 value and value_field hold their last submitted contents until the next submit or reset.
REQ-029 Inactivity counter: reset to 0 on every key_valid, increments each cycle in COLLECT.
REQ-030 When the inactivity counter reaches TIMEOUT_CYCLES-1 -> timeout pulse, buffer/count clear, go IDLE.
REQ-031 Fail counter, 2 bits, saturating: +1 on pin_fail, 0 on pin_ok.
REQ-032 When pin_fail brings the fail count to MAX_TRIES -> go LOCKED next cycle; any partial entry is discarded.
REQ-033 LOCKED: every key_valid is ignored, no key_err; card_out -> fail count 0, go IDLE.
REQ-034 card_out in IDLE/COLLECT -> buffer/count clear, go IDLE; the fail count is cleared.
REQ-035 Same-cycle priority: card_out > pin_fail/pin_ok > timeout > key_valid; a key arriving on the timeout cycle is dropped.
REQ-036 pin_fail and pin_ok asserted together -> treated as pin_fail.

Reset
REQ-037 rst low -> immediately: state IDLE; buffer, value, value_field, digit_count, fail count and inactivity counter 0; value_valid, key_err, timeout and locked 0.
REQ-038 Reset asserted mid-entry or in LOCKED discards all progress; no output pulse is generated on release.

Verification
REQ-039 field_sel=1, keys 4,5,6,ENTER -> value=12'h456, value_field=1, value_valid high exactly one cycle after ENTER, digit_count=0.
REQ-040 Keys 1,2,3,7 -> key_err on the 7, value unchanged; then BACKSPACE,9,ENTER -> value=12'h129.
REQ-041 Keys 7,8 then ENTER -> key_err, digit_count stays 2; BACKSPACE twice -> IDLE, digit_count=0; a third BACKSPACE -> key_err.
REQ-042 Key 1 then no keys for TIMEOUT_CYCLES cycles -> timeout pulse once, digit_count=0, no value_valid.
REQ-043 Three pin_fail strobes -> locked=1; keys 1,2,3,ENTER -> no value_valid, no key_err; card_out -> locked=0; keys 1,2,3,ENTER -> value=12'h123.
REQ-044 rst low while digit_count=2 -> all outputs 0 asynchronously; after release, a single ENTER -> key_err.

Source files
------------

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry: collects up to three BCD digits per field, submits on ENTER,
// discards idle entries and locks out after repeated PIN rejections.
module atm_keypad_entry #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned MAX_TRIES      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic [1:0]  field_sel,
   input  logic        pin_fail,
   input  logic        pin_ok,
   input  logic        card_out,
   output logic [11:0] value,
   output logic [1:0]  value_field,
   output logic        value_valid,
   output logic [1:0]  digit_count,
   output logic        key_err,
   output logic        timeout,
   output logic        locked
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, LOCKED} state_t;

   state_t        state, state_next;
   logic [11:0]   buffer, buf_next;
   logic [1:0]    cnt_next;
   logic [TW-1:0] idle_cnt, idle_next;
   logic [1:0]    fail_cnt, fail_next, fail_inc;
   logic          err_d, submit_d, tmo_d;
   logic          pin_evt, lock_hit, tmo_hit, key_act, key_bad;
   logic          is_digit, is_clear, is_bksp, is_enter;

   assign is_digit = key_code <= 4'd9;
   assign is_clear = key_code == 4'hA;
   assign is_bksp  = key_code == 4'hB;
   assign is_enter = key_code == 4'hC;
   assign key_bad  = (key_code >= 4'hD) || (field_sel == 2'd3);

   // Same-cycle priority chain: card_out, then PIN strobes, then timeout, then keys.
   assign pin_evt  = !card_out && (pin_fail || pin_ok);
   assign fail_inc = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
   assign lock_hit = pin_evt && pin_fail && (32'(fail_inc) == MAX_TRIES);
   assign tmo_hit  = !card_out && !pin_evt && (state == COLLECT) &&
                     (idle_cnt >= TW'(TIMEOUT_CYCLES - 1));
   assign key_act  = key_valid && !card_out && !pin_evt && !tmo_hit && (state != LOCKED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         buffer      <= '0;
         digit_count <= '0;
         idle_cnt    <= '0;
         fail_cnt    <= '0;
         value       <= '0;
         value_field <= '0;
         value_valid <= 1'b0;
         key_err     <= 1'b0;
         timeout     <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state       <= state_next;
         buffer      <= buf_next;
         digit_count <= cnt_next;
         idle_cnt    <= idle_next;
         fail_cnt    <= fail_next;
         value_valid <= submit_d;
         key_err     <= err_d;
         timeout     <= tmo_d;
         locked      <= (state_next == LOCKED);
         if (submit_d) begin
            value       <= buffer;
            value_field <= field_sel;
         end
      end
   end

   always_comb begin
      state_next = state;
      buf_next   = buffer;
      cnt_next   = digit_count;
      idle_next  = (key_valid || state != COLLECT) ? '0 : idle_cnt + 1'b1;
      fail_next  = fail_cnt;
      if (card_out)
         fail_next = '0;
      else if (pin_fail)
         fail_next = fail_inc;
      else if (pin_ok)
         fail_next = '0;

      if (card_out || tmo_hit) begin
         state_next = IDLE;
         buf_next   = '0;
         cnt_next   = '0;
      end else if (lock_hit) begin
         state_next = LOCKED;
         buf_next   = '0;
         cnt_next   = '0;
      end else if (key_act && !key_bad) begin
         case (state)
            IDLE: if (is_digit) begin
               buf_next   = {8'h00, key_code};
               cnt_next   = 2'd1;
               state_next = COLLECT;
            end
            COLLECT: begin
               if (is_digit && digit_count != 2'd3) begin
                  buf_next = {buffer[7:0], key_code};
                  cnt_next = digit_count + 2'd1;
               end else if (is_bksp) begin
                  buf_next = {4'h0, buffer[11:4]};
                  cnt_next = digit_count - 2'd1;
                  if (digit_count == 2'd1) state_next = IDLE;
               end else if (is_clear || (is_enter && digit_count == 2'd3)) begin
                  buf_next   = '0;
                  cnt_next   = '0;
                  state_next = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      tmo_d    = tmo_hit;
      submit_d = key_act && !key_bad && (state == COLLECT) && is_enter &&
                 (digit_count == 2'd3);
      err_d    = key_act && (key_bad ||
                 ((state == IDLE) && !is_digit) ||
                 ((state == COLLECT) && is_digit && (digit_count == 2'd3)) ||
                 ((state == COLLECT) && is_enter && (digit_count != 2'd3)));
   end

endmodule
